// File: rtl/pipelined_add_sub.sv
// Pipelined signed add/sub built from 4-bit CLA slices, carry registered between stages.
// Define SATURATE_EN to clamp the result on signed overflow.
module pipelined_add_sub #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  carry_out
);

  localparam int DW = DATA_WIDTH;
  localparam int SL = DW / STAGES;
  localparam int NC = SL / 4;

  function automatic logic [4:0] cla4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       c0
  );
    logic [3:0] p, g;
    logic [4:0] c;
    p = a ^ b;
    g = a & b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

  function automatic logic [SL:0] add_sl(
    input logic [SL-1:0] a,
    input logic [SL-1:0] b,
    input logic          c
  );
    logic [SL-1:0] s;
    logic          cc;
    logic [4:0]    r;
    s  = '0;
    cc = c;
    for (int i = 0; i < NC; i++) begin
      r = cla4(a[i*4+:4], b[i*4+:4], cc);
      s[i*4+:4] = r[3:0];
      cc = r[4];
    end
    return {cc, s};
  endfunction

  logic          stall;
  logic [DW-1:0] beff;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign beff     = sub ? ~B : B;

  for (genvar s = 0; s < STAGES; s++) begin : g
    localparam int LO = s * SL;
    localparam int HI = LO + SL;

    logic [DW-LO-1:0] ai, bi;
    logic             ci, asi, bsi, vi;
    logic [SL:0]      r;
    logic [HI-1:0]    sum_d;

    assign r = add_sl(ai[SL-1:0], bi[SL-1:0], ci);

    if (s == 0) begin : src
      assign ai    = A;
      assign bi    = beff;
      assign ci    = sub;
      assign asi   = A[DW-1];
      assign bsi   = beff[DW-1];
      assign vi    = in_valid;
      assign sum_d = r[SL-1:0];
    end else begin : src
      // upper operand bits and lower sums skewed in one stage register
      logic [DW-LO-1:0] a_q, b_q;
      logic [LO-1:0]    sum_q;
      logic             c_q, as_q, bs_q, v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
          as_q  <= 1'b0;
          bs_q  <= 1'b0;
          v_q   <= 1'b0;
        end else if (!stall) begin
          a_q   <= g[s-1].ai[DW-LO+SL-1:SL];
          b_q   <= g[s-1].bi[DW-LO+SL-1:SL];
          sum_q <= g[s-1].sum_d;
          c_q   <= g[s-1].r[SL];
          as_q  <= g[s-1].asi;
          bs_q  <= g[s-1].bsi;
          v_q   <= g[s-1].vi;
        end
      end

      assign ai    = a_q;
      assign bi    = b_q;
      assign ci    = c_q;
      assign asi   = as_q;
      assign bsi   = bs_q;
      assign vi    = v_q;
      assign sum_d = {r[SL-1:0], sum_q};
    end
  end

  logic [DW-1:0] res_q;
  logic          cout_q, as_o, bs_o, v_o;
  logic          ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      as_o   <= 1'b0;
      bs_o   <= 1'b0;
      v_o    <= 1'b0;
    end else if (!stall) begin
      res_q  <= g[STAGES-1].sum_d;
      cout_q <= g[STAGES-1].r[SL];
      as_o   <= g[STAGES-1].asi;
      bs_o   <= g[STAGES-1].bsi;
      v_o    <= g[STAGES-1].vi;
    end
  end

  assign ovf = (as_o == bs_o) && (res_q[DW-1] != as_o);

  always_comb begin
    result = res_q;
`ifdef SATURATE_EN
    if (ovf) begin
      result = as_o ? {1'b1, {(DW-1){1'b0}}}
                    : {1'b0, {(DW-1){1'b1}}};
    end
`endif
  end

  assign out_valid = v_o;
  assign overflow  = ovf;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (16-bit; STAGES=2 and STAGES=4 instances).
// Expected values come from an integer arithmetic model.
module tb_pipelined_add_sub;

  typedef struct packed {
    logic [15:0] r;
    logic        o;
    logic        c;
    int          cyc;
  } exp_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_valid4, in_ready4;
  logic [15:0] A, B;
  logic        sub;
  logic        out_valid, out_ready, out_valid4;
  logic [15:0] result, result4;
  logic        overflow, carry_out, overflow4, carry_out4;

  int   ncmp = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   lat_en = 1;
  bit   rnd_on = 0;
  exp_t q0[$];
  exp_t q4[$];

  pipelined_add_sub #(.DATA_WIDTH(16), .STAGES(2)) u (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow),
    .carry_out(carry_out)
  );

  pipelined_add_sub #(.DATA_WIDTH(16), .STAGES(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A), .B(B), .sub(sub),
    .out_valid(out_valid4), .out_ready(1'b1),
    .result(result4), .overflow(overflow4),
    .carry_out(carry_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic s);
    exp_t e;
    int sa, sb, v;
    logic [16:0] w;
    sa = $signed(a);
    sb = $signed(b);
    v  = s ? sa - sb : sa + sb;
    e.o = (v > 32767) || (v < -32768);
    w = s ? {1'b0, a} + {1'b0, ~b} + 17'd1
          : {1'b0, a} + {1'b0, b};
    e.c = w[16];
    e.r = w[15:0];
`ifdef SATURATE_EN
    if (e.o) e.r = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
    e.cyc = 0;
    return e;
  endfunction

  task automatic send(input int d,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic s);
    int n;
    exp_t e;
    A = a;
    B = b;
    sub = s;
    if (d == 0) in_valid = 1'b1;
    else in_valid4 = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if ((d == 0) ? in_ready : in_ready4) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) chk("accept", 0, 1);
    else begin
      e = model(a, b, s);
      e.cyc = cyc;
      if (d == 0) q0.push_back(e);
      else q4.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q4.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk("drain", 0, 1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q0.size() == 0) chk("unexp", 1, 0);
      else begin
        e = q0.pop_front();
        chk("res", result, e.r);
        chk("ovf", overflow, e.o);
        chk("cout", carry_out, e.c);
        if (lat_en) chk("lat", cyc - e.cyc, 2);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid4) begin
      if (q4.size() == 0) chk("unexp4", 1, 0);
      else begin
        e = q4.pop_front();
        chk("res4", result4, e.r);
        chk("ovf4", overflow4, e.o);
        chk("cout4", carry_out4, e.c);
        chk("lat4", cyc - e.cyc, 4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    A = '0;
    B = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_v", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cout", carry_out, 0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_init", in_ready, 1);

    send(0, 16'h1234, 16'h4321, 1'b0);
    send(0, 16'h0005, 16'h0007, 1'b1);
    send(0, 16'h7FFF, 16'h0001, 1'b0);
    send(0, 16'h8000, 16'h0001, 1'b1);
    send(0, 16'h00FF, 16'h0001, 1'b0);
    send(0, 16'h8000, 16'hFFFF, 1'b0);
    send(0, 16'h0000, 16'h0000, 1'b1);
    send(0, 16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    drain();

    lat_en = 0;
    fork
      begin
        send(0, 16'h1111, 16'h2222, 1'b0);
        send(0, 16'h7000, 16'h1000, 1'b0);
        send(0, 16'h0100, 16'h0200, 1'b1);
        send(0, 16'hABCD, 16'h1234, 1'b1);
        in_valid = 1'b0;
      end
      begin
        int n;
        logic [15:0] hr;
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("stall_start", out_valid, 1);
        out_ready = 1'b0;
        hr = result;
        repeat (3) begin
          @(negedge clk);
          chk("stall_rdy", in_ready, 0);
          chk("hold_res", result, hr);
          chk("hold_v", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(0, 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    lat_en = 1;

    send(1, 16'h0FFF, 16'h0001, 1'b0);
    send(1, 16'h00FF, 16'h0001, 1'b0);
    send(1, 16'h7FFF, 16'h0001, 1'b0);
    send(1, 16'h0005, 16'h0007, 1'b1);
    in_valid4 = 1'b0;
    drain();

    send(0, 16'h0102, 16'h0304, 1'b0);
    send(0, 16'h0506, 16'h0708, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_v", out_valid, 0);
    chk("arst_res", result, 0);
    q0.delete();
    #10;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("ghost", out_valid, 0);
    end
    chk("rdy_post", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
